uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmit framer that replaces the purely combinational output select with a registered, self-sequencing frame engine. It accepts a parallel word on a valid pulse, then serialises start, data (LSB first), optional parity and 1 or 2 stop bits. One bit advances per baud-tick enable. It sits between the system-side TX data source and the UART TX pin, and drives TX_OUT directly from a flop (glitch-free).

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9 supported)
CNT_W, $clog2(DATA_WIDTH), width of the data-bit counter (derived, not overridden)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous active-low reset
TICK  input  1  baud enable, one-cycle pulse marking a bit boundary
P_DATA  input  DATA_WIDTH  parallel word to send
DATA_VALID  input  1  request to send P_DATA; honoured only while BUSY=0
PAR_EN  input  1  1 = insert parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
STOP2  input  1  0 = one stop bit, 1 = two stop bits
TX_OUT  output  1  serial line, registered, idle high
BUSY  output  1  high while a frame is in progress
FRAME_DONE  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (async, RST=0): state IDLE, TX_OUT=1, BUSY=0, FRAME_DONE=0, counter=0, shift/config registers cleared. Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: TX_OUT=1. On a rising edge with DATA_VALID=1, latch P_DATA, PAR_EN, PAR_TYP and STOP2, compute parity from the latched word, then go to START. TX_OUT=0 and BUSY=1 from the next cycle (1-cycle latency). TICK is ignored in IDLE.
- Bit advance: in any non-IDLE state, the state or bit changes on the edge where TICK=1. A bit is held until that edge. The first (start) bit may be shorter than a full baud period if acceptance is not tick-aligned; this is the caller's responsibility.
- START (TX_OUT=0): on TICK go to DATA with counter=0.
- DATA (TX_OUT=shift[0]): on TICK shift right and increment the counter. When counter=DATA_WIDTH-1 and TICK=1, go to PARITY if the latched PAR_EN=1, else go to STOP1.
- PARITY: TX_OUT = XOR(latched data) XOR PAR_TYP. On TICK go to STOP1.
- STOP1 (TX_OUT=1): on TICK go to STOP2 if the latched STOP2=1, else go to IDLE.
- STOP2 (TX_OUT=1): on TICK go to IDLE.
- Entry to IDLE: BUSY=0 and FRAME_DONE=1 for exactly that one cycle. A new DATA_VALID is accepted on the same edge that BUSY is seen low (earliest back-to-back accept = first IDLE cycle). This gives zero idle bits between frames only if the source is ready.
- DATA_VALID while BUSY=1 is ignored (no queuing, no error flag). Changes to P_DATA and config inputs during a frame have no effect.
- Frame length in ticks = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2.
- TICK held at 1 every cycle is legal: each bit lasts exactly 1 clock.

Decomposition:
- Package uart_tx_pkg holds:
  - the state enumeration (3-bit encodings IDLE=000, START=001, DATA=010, PARITY=011, STOP1=100, STOP2=101), aligned with the existing TX line-select codes;
  - constants for the idle/start/stop line levels.
- Natural sub-module: uart_tx_parity, a combinational XOR-reduce of DATA_WIDTH bits plus a type select, reusable by the RX checker.
- The FSM, counter, shift register and output flop stay in uart_tx_frame.

Test Plan:
- TICK=1 every cycle, P_DATA=8'hA5, PAR_EN=0, STOP2=0, one DATA_VALID pulse -> TX_OUT per cycle 0,1,0,1,0,0,1,0,1,1, then idle 1. BUSY high for 10 cycles. FRAME_DONE pulses once.
- P_DATA=8'h07, PAR_EN=1, PAR_TYP=0 -> parity bit 1. Repeat with PAR_TYP=1 -> parity bit 0. Frame is 11 ticks.
- STOP2=1, PAR_EN=1, P_DATA=8'hFF -> 12-tick frame with the two final bits high, parity(even)=0.
- TICK every 16 clocks, DATA_VALID asserted mid-frame with a different word -> ignored; only the first word appears on TX_OUT. Each bit is 16 clocks except possibly the start bit.
- RST driven low during DATA bit 3 -> TX_OUT=1 and BUSY=0 asynchronously. A frame issued after release transmits correctly from its start bit.
- DATA_VALID held high continuously, TICK=1 -> back-to-back frames, with a new START on the cycle after the FRAME_DONE cycle and no extra idle bits.

Source files
------------

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Purpose  : Shared types and constants for the UART transmit framer.
//            The state codes match the legacy TX line-select encoding so that
//            debug probes and existing decode tables keep their meaning.
// Contents : tx_state_e   - frame engine state enumeration (3 bits)
//            c_line_*     - serial line levels for idle, start and stop bits
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b010,
    ST_PARITY = 3'b011,
    ST_STOP1  = 3'b100,
    ST_STOP2  = 3'b101
  } tx_state_e;

  localparam logic c_line_idle  = 1'b1;
  localparam logic c_line_start = 1'b0;
  localparam logic c_line_stop  = 1'b1;

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_parity.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_parity
// Purpose  : Combinational parity generator: XOR-reduce of the data word with
//            a type select. Shared with the RX parity checker.
// Ports    : i_data   [DATA_WIDTH-1:0]  word to protect
//            i_odd                      0 = even parity, 1 = odd parity
//            o_parity                   parity bit to transmit / compare
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_parity #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_odd,
  output logic                  o_parity
);

  // Even parity makes the total count of ones even, so it equals the XOR of
  // the data; odd parity is simply its complement.
  assign o_parity = (^i_data) ^ i_odd;

endmodule : uart_tx_parity
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Purpose  : Registered UART transmit frame engine. Accepts a parallel word on
//            a valid pulse and serialises start, data (LSB first), optional
//            parity and one or two stop bits, one bit per baud tick. The
//            serial line is driven straight from a flop.
// Ports    : clk            system clock, rising edge
//            rst_n          asynchronous active-low reset
//            i_tick         baud enable, marks a bit boundary
//            i_p_data       parallel word to send
//            i_data_valid   send request, honoured only while idle
//            i_par_en       1 = insert parity bit
//            i_par_typ      0 = even, 1 = odd parity
//            i_stop2        0 = one stop bit, 1 = two stop bits
//            o_tx_out       serial line, idle high
//            o_busy         high while a frame is in progress
//            o_frame_done   one-cycle pulse on return to idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_tick,
  input  logic [DATA_WIDTH-1:0] i_p_data,
  input  logic                  i_data_valid,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  input  logic                  i_stop2,
  output logic                  o_tx_out,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             r_state,   w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift,   w_shift_nxt;
  logic [CNT_W-1:0]      r_cnt,     w_cnt_nxt;
  logic                  r_par_en,  w_par_en_nxt;
  logic                  r_stop2,   w_stop2_nxt;
  logic                  r_par_bit, w_par_bit_nxt;
  logic                  r_tx,      w_tx_nxt;
  logic                  r_busy,    w_busy_nxt;
  logic                  r_done,    w_done_nxt;
  logic                  w_par;

  // Parity is taken from the word at the moment it is latched, so it always
  // describes exactly the bits that go out on the line.
  uart_tx_parity #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .i_data   (i_p_data),
    .i_odd    (i_par_typ),
    .o_parity (w_par)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_par_en  <= 1'b0;
      r_stop2   <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= c_line_idle;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_par_en  <= w_par_en_nxt;
      r_stop2   <= w_stop2_nxt;
      r_par_bit <= w_par_bit_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_par_en_nxt  = r_par_en;
    w_stop2_nxt   = r_stop2;
    w_par_bit_nxt = r_par_bit;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // Tick is irrelevant here: acceptance is purely on the valid strobe.
        if (i_data_valid) begin
          w_shift_nxt   = i_p_data;
          w_par_en_nxt  = i_par_en;
          w_stop2_nxt   = i_stop2;
          w_par_bit_nxt = w_par;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        if (i_tick) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          w_shift_nxt = {1'b0, r_shift[DATA_WIDTH-1:1]};
          if (r_cnt == c_cnt_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = r_par_en ? ST_PARITY : ST_STOP1;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (i_tick) begin
          w_state_nxt = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (i_tick) begin
          if (r_stop2) begin
            w_state_nxt = ST_STOP2;
          end else begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (i_tick) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The line flop is loaded with the level belonging to the state being
  // entered, so the output changes on the same edge as the state register.
  always_comb begin
    w_tx_nxt = c_line_idle;
    unique case (w_state_nxt)
      ST_IDLE:   w_tx_nxt = c_line_idle;
      ST_START:  w_tx_nxt = c_line_start;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
      ST_PARITY: w_tx_nxt = w_par_bit_nxt;
      ST_STOP1:  w_tx_nxt = c_line_stop;
      ST_STOP2:  w_tx_nxt = c_line_stop;
      default:   w_tx_nxt = c_line_idle;
    endcase
  end

  assign w_busy_nxt = (w_state_nxt != ST_IDLE);

  assign o_tx_out     = r_tx;
  assign o_busy       = r_busy;
  assign o_frame_done = r_done;

endmodule : uart_tx_frame
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Purpose  : Self-checking bench for uart_tx_frame. Expected line sequences
//            are built from the frame format (start, LSB-first data, parity
//            from a ones count, stop bits) and compared on falling edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fast_tick = 1'b1;
  logic          slow_mode = 1'b0;
  logic [3:0]    tick_cnt = 4'd0;
  logic          i_tick;
  logic [DW-1:0] p_data = '0;
  logic          valid = 1'b0;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic          stop2 = 1'b0;
  logic          tx, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  // Free-running divider: one tick every 16 clocks when slow mode is on.
  always @(posedge clk) tick_cnt <= tick_cnt + 4'd1;
  assign i_tick = slow_mode ? (tick_cnt == 4'd15) : fast_tick;

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tick       (i_tick),
    .i_p_data     (p_data),
    .i_data_valid (valid),
    .i_par_en     (par_en),
    .i_par_typ    (par_typ),
    .i_stop2      (stop2),
    .o_tx_out     (tx),
    .o_busy       (busy),
    .o_frame_done (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: the list of line levels, one entry per bit period.
  task automatic build_exp(input logic [DW-1:0] d, input logic pe, input logic pt,
                           input logic s2);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back((($countones(d) % 2) == 1) ^ pt);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask

  // Starts on the negedge showing the start bit (tick every cycle); ends on
  // the negedge of the first idle cycle.
  task automatic walk_frame(input string tag);
    foreach (exp_q[i]) begin
      chk({tag, "_tx"}, tx, exp_q[i]);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_done"}, done, 0);
      @(negedge clk);
    end
    chk({tag, "_end_tx"}, tx, 1);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_done"}, done, 1);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt,
                      input logic s2, input string tag);
    p_data = d; par_en = pe; par_typ = pt; stop2 = s2; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    p_data = ~d;
    build_exp(d, pe, pt, s2);
    walk_frame(tag);
    @(negedge clk);
    chk({tag, "_idle_done"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    logic [DW-1:0] d1, d2;
    int idx, cyc;
    bit finished;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_tx", tx, 1);

    // Directed frames, tick every cycle
    send(8'hA5, 1'b0, 1'b0, 1'b0, "a5");
    send(8'h07, 1'b1, 1'b0, 1'b0, "p07_even");
    send(8'h07, 1'b1, 1'b1, 1'b0, "p07_odd");
    send(8'hFF, 1'b1, 1'b0, 1'b1, "ff_stop2");

    // Random words and configurations
    for (int k = 0; k < 8; k++) begin
      send(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rand");
    end

    // Reset during data bit 3 (bit 3 of 0x35 is 0, so the line must jump high)
    p_data = 8'h35; par_en = 1'b0; stop2 = 1'b0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_bit3_tx", tx, 0);
    chk("mid_bit3_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_tx", tx, 1);
    send(8'hC3, 1'b1, 1'b1, 1'b1, "post_rst");

    // Back-to-back frames with valid held high
    d1 = DW'($urandom); d2 = DW'($urandom);
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    p_data = d1; valid = 1'b1;
    @(negedge clk);
    p_data = d2;
    build_exp(d1, 1'b0, 1'b0, 1'b0);
    walk_frame("b2b_first");
    @(negedge clk);
    build_exp(d2, 1'b0, 1'b0, 1'b0);
    walk_frame("b2b_second");
    valid = 1'b0;
    @(negedge clk);
    chk("b2b_after_busy", busy, 0);
    chk("b2b_after_tx", tx, 1);

    // Slow tick with a foreign word requested mid-frame
    slow_mode = 1'b1;
    d1 = DW'($urandom);
    p_data = d1; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    build_exp(d1, 1'b1, 1'b0, 1'b0);
    idx = 0; cyc = 0; finished = 1'b0;
    for (int c = 0; c < 400 && !finished; c++) begin
      if (!busy) begin
        finished = 1'b1;
      end else begin
        cyc++;
        if (idx < exp_q.size()) chk("slow_tx", tx, exp_q[idx]);
        else chk("slow_overrun", idx, exp_q.size());
        if (c == 40) begin
          valid = 1'b1;
          p_data = ~d1;
        end else if (c == 42) begin
          valid = 1'b0;
        end
        if (i_tick) begin
          if (idx > 0) chk("slow_bit_len", cyc, 16);
          cyc = 0;
          idx++;
        end
        @(negedge clk);
      end
    end
    if (!finished) chk("slow_timeout", busy, 0);
    chk("slow_bits_sent", idx, exp_q.size());
    chk("slow_end_done", done, 1);
    chk("slow_end_tx", tx, 1);
    slow_mode = 1'b0;
    @(negedge clk);
    chk("slow_no_requeue", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_frame
`default_nettype wire
